// File: rtl/mac_pkg.sv
// Shared definitions for the precision-scalable MAC datapath: accumulator width,
// precision levels, lane geometry and drainer state encoding.
package mac_pkg;

  localparam int ACC_W       = 56;
  localparam int EXT_W       = ACC_W + 1;
  localparam int LANE_W_FULL = 56;
  localparam int LANE_W_W4   = 28;
  localparam int LANE_W_W2   = 14;
  localparam int MAX_SHIFT   = 55;

  typedef enum logic [1:0] {
    FULL = 2'b00,
    W4   = 2'b01,
    W2   = 2'b10,
    RSVD = 2'b11
  } prec_level_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } drain_state_t;

  function automatic logic [2:0] lane_count(prec_level_t p);
    case (p)
      FULL:    return 3'd1;
      W4:      return 3'd2;
      W2:      return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mac_result_drainer_if.sv
// Capture request and lane stream of the MAC result drainer.
// Optional relu input is present when MAC_DRAIN_RELU_EN is defined.
interface mac_result_drainer_if #(
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
);
  import mac_pkg::*;

  // Both streams: a beat/capture transfers on a rising clk edge where valid && ready;
  // valid never depends on ready, and a held beat keeps its payload stable.
  logic               in_valid;
  logic               in_ready;
  logic [ACC_W-1:0]   acc_result;
  logic [1:0]         prec_level;
  logic [SHIFT_W-1:0] shift;
`ifdef MAC_DRAIN_RELU_EN
  logic               relu;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic [1:0]         out_lane;
  logic               out_last;
  logic               err_prec;

  modport master (
`ifdef MAC_DRAIN_RELU_EN
    output relu,
`endif
    output in_valid, acc_result, prec_level, shift, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, err_prec
  );

  modport slave (
`ifdef MAC_DRAIN_RELU_EN
    input  relu,
`endif
    input  in_valid, acc_result, prec_level, shift, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, err_prec
  );

endinterface

// File: rtl/lane_requant.sv
// Combinational lane extraction and requantization: sign-extend, round half up,
// arithmetic shift, saturate to OUT_W (optional relu under MAC_DRAIN_RELU_EN).
module lane_requant
  import mac_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  prec_level_t      prec,
  input  logic [1:0]       lane,
  input  logic [5:0]       shift,
`ifdef MAC_DRAIN_RELU_EN
  input  logic             relu,
`endif
  output logic [OUT_W-1:0] result
);

  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;

  logic [LANE_W_W4-1:0]     sel28;
  logic [LANE_W_W2-1:0]     sel14;
  logic signed [EXT_W-1:0]  ext;
  logic signed [EXT_W-1:0]  half;
  logic signed [EXT_W-1:0]  rounded;
  logic signed [EXT_W-1:0]  shifted;
  logic                     zero_neg;

  always_comb begin
    sel28 = lane[0] ? acc[55:28] : acc[27:0];
    case (lane)
      2'd0:    sel14 = acc[13:0];
      2'd1:    sel14 = acc[27:14];
      2'd2:    sel14 = acc[41:28];
      default: sel14 = acc[55:42];
    endcase
  end

  always_comb begin
    case (prec)
      FULL:    ext = {acc[ACC_W-1], acc};
      W4:      ext = {{(EXT_W - LANE_W_W4){sel28[LANE_W_W4-1]}}, sel28};
      W2:      ext = {{(EXT_W - LANE_W_W2){sel14[LANE_W_W2-1]}}, sel14};
      default: ext = '0;
    endcase
  end

  // 57 bits keep the rounding add of a full 56-bit lane free of overflow.
  always_comb begin
    half    = (shift == 6'd0) ? '0 : (EXT_W'(1) << (shift - 6'd1));
    rounded = ext + half;
    shifted = rounded >>> shift;
  end

`ifdef MAC_DRAIN_RELU_EN
  assign zero_neg = relu && (shifted < 0);
`else
  assign zero_neg = 1'b0;
`endif

  always_comb begin
    if (zero_neg)             result = '0;
    else if (shifted > SAT_HI) result = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) result = SAT_LO[OUT_W-1:0];
    else                       result = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/mac_result_drainer.sv
// Captures a final MAC accumulator, splits it into 1/2/4 lanes and streams the
// requantized lanes one beat per cycle. Optional feature macro: MAC_DRAIN_RELU_EN.
module mac_result_drainer
  import mac_pkg::*;
#(
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  mac_result_drainer_if.slave  bus,
  output drain_state_t         state_dbg
);

  drain_state_t     state, state_nxt;
  logic [ACC_W-1:0] acc_q;
  prec_level_t      prec_q;
  logic [5:0]       shift_q;
  logic [1:0]       lane_q;
  logic [OUT_W-1:0] data_q;
  logic             last_q;
  logic             err_q;
`ifdef MAC_DRAIN_RELU_EN
  logic             relu_q;
  logic             rq_relu;
`endif

  logic             in_ready, out_valid;
  logic             capture, advance, legal_in;
  prec_level_t      in_prec;
  logic [5:0]       shift_clamped;

  logic [ACC_W-1:0] rq_acc;
  prec_level_t      rq_prec;
  logic [1:0]       rq_lane;
  logic [5:0]       rq_shift;
  logic [OUT_W-1:0] rq_result;
  logic             rq_last;

  assign in_prec       = prec_level_t'(bus.prec_level);
  assign legal_in      = (in_prec != RSVD);
  assign shift_clamped = (bus.shift > SHIFT_W'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : 6'(bus.shift);
  assign capture       = bus.in_valid && in_ready;
  assign advance       = out_valid && bus.out_ready && !last_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (capture && legal_in) state_nxt = ST_EMIT;
      ST_EMIT: if (bus.out_ready && last_q)
                 state_nxt = (capture && legal_in) ? ST_EMIT : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A new capture is only possible when no beat is pending or the last one leaves now.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_EMIT: begin
        out_valid = 1'b1;
        in_ready  = last_q && bus.out_ready;
      end
      default: in_ready = 1'b1;
    endcase
  end

  // The requantizer sees the incoming capture directly so lane 0 is ready one cycle later.
  always_comb begin
    if (capture) begin
      rq_acc   = bus.acc_result;
      rq_prec  = in_prec;
      rq_lane  = 2'd0;
      rq_shift = shift_clamped;
`ifdef MAC_DRAIN_RELU_EN
      rq_relu  = bus.relu;
`endif
    end else begin
      rq_acc   = acc_q;
      rq_prec  = prec_q;
      rq_lane  = lane_q + 2'd1;
      rq_shift = shift_q;
`ifdef MAC_DRAIN_RELU_EN
      rq_relu  = relu_q;
`endif
    end
    rq_last = (({1'b0, rq_lane} + 3'd1) == lane_count(rq_prec));
  end

  lane_requant #(.OUT_W(OUT_W)) u_lane_requant (
    .acc    (rq_acc),
    .prec   (rq_prec),
    .lane   (rq_lane),
    .shift  (rq_shift),
`ifdef MAC_DRAIN_RELU_EN
    .relu   (rq_relu),
`endif
    .result (rq_result)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q   <= '0;
      prec_q  <= FULL;
      shift_q <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MAC_DRAIN_RELU_EN
      relu_q  <= 1'b0;
`endif
    end else if (capture) begin
      acc_q   <= bus.acc_result;
      prec_q  <= in_prec;
      shift_q <= shift_clamped;
      lane_q  <= 2'd0;
      data_q  <= rq_result;
      last_q  <= rq_last;
      if (!legal_in) err_q <= 1'b1;
`ifdef MAC_DRAIN_RELU_EN
      relu_q  <= bus.relu;
`endif
    end else if (advance) begin
      lane_q  <= rq_lane;
      data_q  <= rq_result;
      last_q  <= rq_last;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_lane  = lane_q;
  assign bus.out_last  = last_q;
  assign bus.err_prec  = err_q;
  assign state_dbg     = state;

endmodule
